// File: rtl/running_average_if.sv
// Sample-stream bundle for running_average: strobe/sample/leaving-sample from upstream,
// window average and fill status back.
interface running_average_if #(
  parameter int data_width = 8,
  parameter int LOG2N      = 12
);
  logic                  read;
  logic [data_width-1:0] data_in;
  logic [data_width-1:0] oldest;
  logic                  clear;
  logic [data_width-1:0] avg_out;
  logic                  valid;
  logic [LOG2N:0]        fill_count;

  modport master (
    output read, data_in, oldest, clear,
    input  avg_out, valid, fill_count
  );

  modport slave (
    input  read, data_in, oldest, clear,
    output avg_out, valid, fill_count
  );
endinterface

// File: rtl/running_average.sv
// Boxcar average over the last N samples, kept as a running sum that adds the incoming
// sample and subtracts the one leaving the upstream buffer.
module running_average #(
  parameter int data_width = 8,
  parameter int N          = 4096,
  parameter int LOG2N      = 12
) (
  input  logic             clk,
  input  logic             reset,
  running_average_if.slave bus
);
  localparam int             SUM_W    = data_width + LOG2N;
  localparam logic [LOG2N:0] FULL_CNT = (LOG2N + 1)'(N);
  localparam logic [0:0]     FILL     = 1'b0;
  localparam logic [0:0]     RUN      = 1'b1;

  // Divide by the window length; the sum never exceeds N*(2^data_width-1), so the
  // quotient always fits in data_width bits.
  function automatic logic [data_width-1:0] window_avg(input logic [SUM_W-1:0] s);
    return data_width'(s >> LOG2N);
  endfunction

  logic [0:0]            state_p0;
  logic [0:0]            state_nxt;
  logic [SUM_W-1:0]      sum_p0;
  logic [SUM_W-1:0]      sum_nxt;
  logic [SUM_W-1:0]      leaving;
  logic [LOG2N:0]        fill_p0;
  logic [LOG2N:0]        fill_nxt;
  logic [data_width-1:0] avg_p1;
  logic                  vld_p1;

  // Stage 0: next sum and fill state. While filling, the upstream buffer still holds
  // stale samples from before reset/clear, so the leaving sample is masked.
  always_comb begin
    leaving   = (state_p0 == RUN) ? SUM_W'(bus.oldest) : '0;
    sum_nxt   = sum_p0 + SUM_W'(bus.data_in) - leaving;
    fill_nxt  = fill_p0;
    state_nxt = state_p0;
    if (state_p0 == FILL) begin
      fill_nxt = fill_p0 + (LOG2N + 1)'(1);
      if (fill_nxt == FULL_CNT) begin
        state_nxt = RUN;
      end
    end
  end

  // Stage 1: registered sum, fill count, state and average.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= FILL;
      sum_p0   <= '0;
      fill_p0  <= '0;
      avg_p1   <= '0;
    end else if (bus.clear) begin
      state_p0 <= FILL;
      sum_p0   <= '0;
      fill_p0  <= '0;
      avg_p1   <= '0;
    end else if (bus.read) begin
      state_p0 <= state_nxt;
      sum_p0   <= sum_nxt;
      fill_p0  <= fill_nxt;
      avg_p1   <= window_avg(sum_nxt);
    end
  end

  assign vld_p1         = (state_p0 == RUN);
  assign bus.avg_out    = avg_p1;
  assign bus.valid      = vld_p1;
  assign bus.fill_count = fill_p0;
endmodule

// File: tb/tb_running_average.sv
// Directed bench for running_average (N=4): a queue of accepted samples plus a model of
// the upstream shift buffer predict avg_out/valid/fill_count every cycle.
module tb_running_average;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int LN = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  running_average_if #(.data_width(DW), .LOG2N(LN)) bus ();

  running_average #(.data_width(DW), .N(N), .LOG2N(LN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Upstream buffer: not affected by this block's reset/clear, starts full of 200s.
  logic [DW-1:0] ubuf [N] = '{8'd200, 8'd200, 8'd200, 8'd200};
  assign bus.oldest = ubuf[N-1];

  always @(posedge clk) begin
    if (bus.read) begin
      ubuf[0] <= bus.data_in;
      for (int i = 1; i < N; i++) ubuf[i] <= ubuf[i-1];
    end
  end

  // Window model: the samples accepted since the last reset/clear, newest N kept.
  int hist[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) hist.delete();
    else if (bus.clear) hist.delete();
    else if (bus.read) begin
      hist.push_back(int'(bus.data_in));
      if (hist.size() > N) void'(hist.pop_front());
    end
  end

  function automatic int exp_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / N;
  endfunction

  always @(negedge clk) begin
    check("model_avg",   32'(bus.avg_out),    32'(exp_avg()));
    check("model_valid", 32'(bus.valid),      32'(hist.size() == N));
    check("model_fill",  32'(bus.fill_count), 32'(hist.size()));
  end

  task automatic do_read(input logic [DW-1:0] d);
    bus.data_in = d;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    bus.read    = 1'b0;
  endtask

  task automatic check_out(input string tag, input int a, input int v, input int f);
    check({tag, "_avg"},   32'(bus.avg_out),    32'(a));
    check({tag, "_valid"}, 32'(bus.valid),      32'(v));
    check({tag, "_fill"},  32'(bus.fill_count), 32'(f));
  endtask

  initial begin
    bus.read    = 1'b0;
    bus.clear   = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    reset = 1'b1;

    // Partial fill, then an asynchronous reset pulse between edges.
    do_read(8'd8);
    do_read(8'd8);
    check_out("prepulse", 4, 0, 2);
    #2 reset = 1'b0;
    #1 check_out("async_rst", 0, 0, 0);
    reset = 1'b1;

    // Fill with 8s while upstream still presents stale 200s.
    for (int i = 1; i <= N; i++) begin
      do_read(8'd8);
      check("fill_step", 32'(bus.fill_count), 32'(i));
      check("fill_valid", 32'(bus.valid), 32'(i == N));
    end
    check("fill_avg", 32'(bus.avg_out), 32'd8);

    // Running update: 8+8+8+12 = 36 -> 9, then idle hold.
    do_read(8'd12);
    check_out("run", 9, 1, 4);
    repeat (5) @(posedge clk);
    #1 check_out("idle", 9, 1, 4);

    // Clear wins over a simultaneous read.
    bus.clear = 1'b1;
    do_read(8'd50);
    bus.clear = 1'b0;
    check_out("clear", 0, 0, 0);

    // Full-scale samples: no overflow.
    for (int i = 0; i < N; i++) do_read(8'd255);
    check_out("max_fill", 255, 1, 4);
    for (int i = 0; i < 3; i++) begin
      do_read(8'd255);
      check_out("max_run", 255, 1, 4);
    end

    // Reset mid-RUN for two edges with a read strobe that must be ignored.
    reset       = 1'b0;
    bus.read    = 1'b1;
    bus.data_in = 8'd99;
    repeat (2) @(posedge clk);
    #1 check_out("mid_rst", 0, 0, 0);
    bus.read = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < N; i++) do_read(8'd4);
    check_out("refill", 4, 1, 4);
    do_read(8'd20);
    check_out("after_refill", 8, 1, 4);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
